// File: rtl/dec_entry.sv
// Decimal operand entry: debounced-by-sync key events append, delete or clear
// digits of a binary operand (multiply-by-10 on entry, restoring divide-by-10 on delete).
module dec_entry #(
  parameter int WIDTH      = 20,
  parameter int MAX_DIGITS = 6,
  parameter int CNT_W      = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             key_dig,
  input  logic             key_del,
  input  logic             key_clr,
  input  logic [3:0]       digit_sw,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] ndigits,
  output logic             full,
  output logic             err,
  output logic             busy,
  output logic             done
);

  localparam int DCW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;
  localparam logic [1:0] S_DIV  = 2'd3;

  logic [1:0]       r_state;
  logic [2:0]       r_sync_dig, r_sync_del, r_sync_clr;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_ndig;
  logic             r_err;
  logic             r_done;
  logic [3:0]       r_digit;
  logic [WIDTH+3:0] r_acc;
  logic [3:0]       r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [DCW-1:0]   r_cnt;

  logic             w_ev_dig, w_ev_del, w_ev_clr;
  logic             w_clr, w_del, w_dig;
  logic             w_full;
  logic [WIDTH+3:0] w_data_x;
  logic [WIDTH+3:0] w_mul;
  logic [4:0]       w_rem_sh;
  logic             w_qbit;
  logic [3:0]       w_rem_nx;

  // Bit 2 holds the previous synchronized level; a 1->0 step is one press event.
  assign w_ev_dig = r_sync_dig[2] & ~r_sync_dig[1];
  assign w_ev_del = r_sync_del[2] & ~r_sync_del[1];
  assign w_ev_clr = r_sync_clr[2] & ~r_sync_clr[1];

  assign w_clr = w_ev_clr;
  assign w_del = w_ev_del & ~w_ev_clr;
  assign w_dig = w_ev_dig & ~w_ev_del & ~w_ev_clr;

  assign w_full   = (r_ndig == CNT_W'(MAX_DIGITS));
  assign w_data_x = {4'b0000, r_data};
  assign w_mul    = (w_data_x << 3) + (w_data_x << 1);

  // Restoring step: quotient bits shift into r_quo as dividend bits shift out.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_qbit   = (w_rem_sh >= 5'd10);
  assign w_rem_nx = w_qbit ? 4'(w_rem_sh - 5'd10) : w_rem_sh[3:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_sync_dig <= '1;
      r_sync_del <= '1;
      r_sync_clr <= '1;
      r_data     <= '0;
      r_ndig     <= '0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_digit    <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
    end else begin
      r_sync_dig <= {r_sync_dig[1:0], key_dig};
      r_sync_del <= {r_sync_del[1:0], key_del};
      r_sync_clr <= {r_sync_clr[1:0], key_clr};
      r_done     <= 1'b0;
      if (w_clr) begin
        r_data  <= '0;
        r_ndig  <= '0;
        r_err   <= 1'b0;
        r_done  <= 1'b1;
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_del) begin
              if (r_ndig != '0) begin
                r_rem   <= '0;
                r_quo   <= r_data;
                r_cnt   <= DCW'(WIDTH);
                r_state <= S_DIV;
              end
            end else if (w_dig) begin
              if (digit_sw > 4'd9) begin
                r_err <= 1'b1;
              end else if (!w_full) begin
                r_digit <= digit_sw;
                r_err   <= 1'b0;
                r_state <= S_MUL;
              end
            end
          end
          S_MUL: begin
            r_acc   <= w_mul;
            r_state <= S_ADD;
          end
          S_ADD: begin
            r_data  <= WIDTH'(r_acc + {{WIDTH{1'b0}}, r_digit});
            r_ndig  <= r_ndig + CNT_W'(1);
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          S_DIV: begin
            if (r_cnt != '0) begin
              r_rem <= w_rem_nx;
              r_quo <= {r_quo[WIDTH-2:0], w_qbit};
              r_cnt <= r_cnt - DCW'(1);
            end else begin
              r_data  <= r_quo;
              r_ndig  <= r_ndig - CNT_W'(1);
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign data    = r_data;
  assign ndigits = r_ndig;
  assign full    = w_full;
  assign err     = r_err;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;

endmodule

// File: doc/dec_entry.md
Name: dec_entry

Overview:
- Operand-entry block for the calculator. It is the inverse of the binary-to-BCD display path.
- Accepts decimal digits one at a time from the slide switches, qualified by push-button presses.
- Accumulates them into a binary operand that feeds the ALU and display stages.
- Supports clear, and a backspace that removes the last digit using a multi-cycle divide-by-10.

Parameters:
- WIDTH, 20: width of the binary operand. Must hold 10^MAX_DIGITS - 1.
- MAX_DIGITS, 6: maximum number of decimal digits accepted.
- CNT_W, 3: width of the digit counter. Must satisfy 2^CNT_W > MAX_DIGITS.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- key_dig  in  1  raw push-button, active-low; a press enters digit_sw.
- key_del  in  1  raw push-button, active-low; a press removes the last digit.
- key_clr  in  1  raw push-button, active-low; a press clears the operand.
- digit_sw  in  4  BCD digit to enter; values 10..15 are invalid.
- data  out  WIDTH  current binary operand.
- ndigits  out  CNT_W  number of digits currently entered.
- full  out  1  high when ndigits == MAX_DIGITS.
- err  out  1  sticky; set on a rejected digit press.
- busy  out  1  high while in MUL, ADD or DIV.
- done  out  1  one-cycle pulse when data/ndigits have just been updated by a digit, delete or clear.

Behaviour:
- Reset (RST=1 at an edge): data=0, ndigits=0, err=0, done=0, busy=0, state=IDLE. Synchronizers are preset to 1 (released).
- Input conditioning: each key passes a 2-flop synchronizer.
  - A press event is a 1->0 transition of the synchronized level. Exactly one event is generated per press, regardless of hold time.
  - A release (0->1) generates nothing.
  - A raw falling edge produces its event 3 edges later.
- Event priority when several events occur in one cycle: clr > del > dig. Lower-priority events in that cycle are discarded.
- Events arriving while busy=1 are discarded, except clr (not queued).
- digit_sw is sampled in the event cycle, not at the raw press.
- States:
  - IDLE:
    - clr event -> data=0, ndigits=0, err=0, done=1, stay IDLE.
    - dig event with digit_sw > 9 -> err=1; data and ndigits unchanged; no done; stay IDLE.
    - dig event while full -> ignored entirely; err unchanged.
    - dig event otherwise -> latch digit, err=0, go MUL.
    - del event with ndigits==0 -> ignored.
    - del event otherwise -> load divider (remainder=0, dividend=data, count=WIDTH), go DIV.
  - MUL (1 cycle): acc = (data<<3) + (data<<1), computed in WIDTH+4 bits; go ADD.
  - ADD (1 cycle): data = acc + digit, truncated to WIDTH (no overflow possible by the MAX_DIGITS rule); ndigits+1; done=1; go IDLE.
    - Digit-entry latency: event cycle E -> data valid and done high in cycle E+2.
  - DIV: restoring division by 10, one quotient bit per cycle, MSB first, WIDTH cycles.
    - Shift remainder left, bringing in the next dividend bit.
    - If remainder >= 10: subtract 10 and set the quotient bit to 1.
    - After the last bit: data = quotient, ndigits-1, done=1, go IDLE.
    - Delete latency: WIDTH+1 cycles from the event (21 for the defaults).
- busy = (state != IDLE). done is high only in the update cycle.
- A clr event in MUL, ADD or DIV aborts the operation: data=0, ndigits=0, err=0, done=1, state=IDLE, next edge. No partial result is written.
- RST asserted mid-operation: reset values at the next edge; no done pulse.
- Leading zeros count as digits: entering 0 increments ndigits; data is unchanged in value.
- full is combinational from ndigits.

Test Plan:
- Reset with keys released -> data=0, ndigits=0, err=0, busy=0, done=0.
- Enter digits 1,2,3,4,5,6 -> data=123456 (0x1E240), ndigits=6, full=1, one done per digit at E+2. A seventh press with 7 -> no change, no done, err=0.
- From 999999: del -> busy for 21 cycles, then data=99999, ndigits=5. Five more dels -> data=0, ndigits=0. A further del -> ignored, no done.
- digit_sw=12 press -> err=1, data unchanged. A following valid 4 -> err=0 and data appended with 4.
- Hold key_dig low for 100 cycles -> exactly one digit entered. Pressing key_dig and key_clr in the same cycle -> clear only.
- Start a del on 4321, assert clr at DIV cycle 10 -> data=0, ndigits=0, done one cycle later, busy=0. Assert RST during MUL -> all reset values, no done.
